// File: rtl/obtc_pkg.sv
// Shared constants and state encoding for the PE result sequencer.
package obtc_pkg;

   localparam int NPE      = 64;
   localparam int NBEAT    = 16;
   localparam int PE_LAT   = 1;
   localparam int ACC_W    = 14;
   localparam int NIB_LSB  = 10;
   localparam int DIGEST_W = 256;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLR     = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_RUN     = 3'd3;
   localparam logic [2:0] S_FLUSH   = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;
   localparam logic [2:0] S_OUT     = 3'd6;

endpackage

// File: rtl/pe_nibble_pack.sv
// Reduces PE accumulators to nibbles, packs lane pairs into bytes and XORs with the digest.
module pe_nibble_pack
   import obtc_pkg::*;
#(
   parameter int P_NPE     = NPE,
   parameter int P_ACC_W   = ACC_W,
   parameter int P_NIB_LSB = NIB_LSB
) (
   input  logic [P_NPE*P_ACC_W-1:0] pe_out,
   input  logic [DIGEST_W-1:0]      digest,
   output logic [DIGEST_W-1:0]      result
);

   // Only a 4-bit window of each accumulator matters; the rest is dropped on purpose.
   logic unused_pe;
   assign unused_pe = ^pe_out;

   for (genvar j = 0; j < P_NPE/2; j++) begin : g_byte
      assign result[8*j +: 8] = {pe_out[(2*j)*P_ACC_W + P_NIB_LSB +: 4],
                                 pe_out[(2*j+1)*P_ACC_W + P_NIB_LSB +: 4]}
                                ^ digest[8*j +: 8];
   end

   if (P_NPE*4 < DIGEST_W) begin : g_pad
      assign result[DIGEST_W-1:P_NPE*4] = digest[DIGEST_W-1:P_NPE*4];
   end

endmodule

// File: rtl/pe_result_sequencer.sv
// Sequences the PE array through one matrix-vector product per digest and returns product XOR digest.
//
// state   | meaning
// IDLE    | waiting for a digest (hash_ready=1)
// CLR     | clear all PE accumulators
// SETTLE  | let the registered DSP clear land before beat 0
// RUN     | NBEAT accumulate beats, beat_idx = beat
// FLUSH   | PE_LAT drain cycles with zero operands
// CAPTURE | register packed result
// OUT     | hold result until res_ready
module pe_result_sequencer
   import obtc_pkg::*;
#(
   parameter int P_NPE     = NPE,
   parameter int P_NBEAT   = NBEAT,
   parameter int P_PE_LAT  = PE_LAT,
   parameter int P_ACC_W   = ACC_W,
   parameter int P_NIB_LSB = NIB_LSB
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         hash_valid,
   output logic                         hash_ready,
   input  logic [DIGEST_W-1:0]          hash_data,
   output logic                         pe_clr,
   output logic                         pe_en,
   output logic [$clog2(P_NBEAT)-1:0]   beat_idx,
   output logic                         operand_zero,
   input  logic [P_NPE*P_ACC_W-1:0]     pe_out,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [DIGEST_W-1:0]          res_data
);

   localparam int BW = $clog2(P_NBEAT);
   localparam int FW = (P_PE_LAT > 1) ? $clog2(P_PE_LAT) : 1;

   state_t                state;
   logic [BW-1:0]         beat;
   logic [FW-1:0]         flush_cnt;
   logic [DIGEST_W-1:0]   digest;
   logic [DIGEST_W-1:0]   packed_res;

   pe_nibble_pack #(
      .P_NPE     (P_NPE),
      .P_ACC_W   (P_ACC_W),
      .P_NIB_LSB (P_NIB_LSB)
   ) u_pack (
      .pe_out (pe_out),
      .digest (digest),
      .result (packed_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         beat      <= '0;
         flush_cnt <= '0;
         digest    <= '0;
         res_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hash_valid) begin
                  digest <= hash_data;
                  state  <= S_CLR;
               end
            end
            S_CLR:    state <= S_SETTLE;
            S_SETTLE: begin
               beat  <= '0;
               state <= S_RUN;
            end
            S_RUN: begin
               if (beat == BW'(P_NBEAT-1)) begin
                  beat      <= '0;
                  flush_cnt <= FW'(P_PE_LAT-1);
                  state     <= (P_PE_LAT == 0) ? S_CAPTURE : S_FLUSH;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == '0) state <= S_CAPTURE;
               else                 flush_cnt <= flush_cnt - 1'b1;
            end
            S_CAPTURE: begin
               res_data <= packed_res;
               state    <= S_OUT;
            end
            S_OUT: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign hash_ready   = (state == S_IDLE);
   assign pe_clr       = (state == S_CLR);
   assign pe_en        = (state == S_RUN) || (state == S_FLUSH);
   assign operand_zero = (state == S_FLUSH);
   assign res_valid    = (state == S_OUT);

   // FLUSH keeps the last beat address so the ROM/mux stay quiet while operands are forced to zero.
   always_comb begin
      beat_idx = '0;
      if (state == S_RUN)        beat_idx = beat;
      else if (state == S_FLUSH) beat_idx = BW'(P_NBEAT-1);
   end

endmodule

// File: tb/tb_pe_result_sequencer.sv
// Directed and randomized checks of pe_result_sequencer against a lane/byte arithmetic model.
module tb_pe_result_sequencer;

   localparam int NPE_T = 64;
   localparam int ACC_T = 14;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     hash_valid = 1'b0;
   logic                     hash_ready;
   logic [255:0]             hash_data = '0;
   logic                     pe_clr;
   logic                     pe_en;
   logic [3:0]               beat_idx;
   logic                     operand_zero;
   logic [NPE_T*ACC_T-1:0]   pe_out = '0;
   logic                     res_valid;
   logic                     res_ready = 1'b0;
   logic [255:0]             res_data;

   int checks = 0;
   int passed = 0;
   logic [13:0] lane_val [NPE_T];

   pe_result_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .hash_valid   (hash_valid),
      .hash_ready   (hash_ready),
      .hash_data    (hash_data),
      .pe_clr       (pe_clr),
      .pe_en        (pe_en),
      .beat_idx     (beat_idx),
      .operand_zero (operand_zero),
      .pe_out       (pe_out),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // Reference: nibble = floor(acc / 1024) mod 16; byte j = 16*nib[2j] + nib[2j+1], XOR digest byte.
   function automatic logic [255:0] model(input logic [255:0] dg);
      logic [255:0] r;
      int hi, lo;
      r = '0;
      for (int j = 0; j < NPE_T/2; j++) begin
         hi = (int'(lane_val[2*j]) / 1024) % 16;
         lo = (int'(lane_val[2*j+1]) / 1024) % 16;
         r[8*j +: 8] = 8'(hi*16 + lo) ^ dg[8*j +: 8];
      end
      return r;
   endfunction

   task automatic fill_lanes(input logic [13:0] v);
      for (int i = 0; i < NPE_T; i++) lane_val[i] = v;
   endtask

   task automatic apply_lanes();
      for (int i = 0; i < NPE_T; i++) pe_out[i*ACC_T +: ACC_T] = lane_val[i];
   endtask

   task automatic run_txn(input logic [255:0] dg, input int bp, input bit noise, input string tag);
      logic [255:0] exp_r;
      int cnt;
      exp_r = model(dg);
      apply_lanes();
      res_ready = (bp == 0);
      cnt = 0;
      while (!hash_ready && cnt < 50) begin tick(); cnt++; end
      hash_data  = dg;
      hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      cnt = 1;
      while (!res_valid && cnt < 40) begin
         hash_valid = noise && (cnt == 10);
         if (noise) hash_data = rand256();
         tick();
         cnt++;
      end
      hash_valid = 1'b0;
      chk({tag, "_latency"}, 256'(cnt), 256'(21));
      chk({tag, "_result"}, res_data, exp_r);
      if (bp > 0) begin
         for (int k = 0; k < bp; k++) begin
            hash_valid = noise && (k == 3);
            hash_data  = rand256();
            tick();
            chk({tag, "_bp_valid"}, 256'(res_valid), 256'(1));
            chk({tag, "_bp_data"}, res_data, exp_r);
            chk({tag, "_bp_hready"}, 256'(hash_ready), 256'(0));
         end
         hash_valid = 1'b0;
         res_ready  = 1'b1;
      end
      tick();
      chk({tag, "_done_hready"}, 256'(hash_ready), 256'(1));
      chk({tag, "_done_rvalid"}, 256'(res_valid), 256'(0));
      res_ready = 1'b0;
   endtask

   initial begin
      logic [255:0] dg, exp_r;
      int cnt;

      fill_lanes(14'h0000);
      apply_lanes();
      repeat (3) tick();
      chk("rst_hready", 256'(hash_ready), 256'(1));
      chk("rst_pe_clr", 256'(pe_clr), 256'(0));
      chk("rst_pe_en", 256'(pe_en), 256'(0));
      chk("rst_beat", 256'(beat_idx), 256'(0));
      chk("rst_opzero", 256'(operand_zero), 256'(0));
      chk("rst_rvalid", 256'(res_valid), 256'(0));
      chk("rst_rdata", res_data, 256'(0));
      rst = 1'b0;
      tick();

      // Cycle-by-cycle timing of one product, result held (res_ready low)
      fill_lanes(14'h3C00);
      apply_lanes();
      hash_data  = '0;
      hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         chk($sformatf("t%0d_pe_clr", c), 256'(pe_clr), 256'(c == 1));
         chk($sformatf("t%0d_pe_en", c), 256'(pe_en), 256'(c >= 3 && c <= 19));
         chk($sformatf("t%0d_opzero", c), 256'(operand_zero), 256'(c == 19));
         chk($sformatf("t%0d_rvalid", c), 256'(res_valid), 256'(c >= 21));
         chk($sformatf("t%0d_hready", c), 256'(hash_ready), 256'(0));
         if (c >= 3 && c <= 19)
            chk($sformatf("t%0d_beat", c), 256'(beat_idx), 256'((c <= 18) ? c - 3 : 15));
         tick();
      end
      chk("all_3c00", res_data, {256{1'b1}});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t_handshake_hready", 256'(hash_ready), 256'(1));

      // Directed nibble-window patterns
      fill_lanes(14'h0400);
      run_txn({32{8'hFF}}, 0, 1'b0, "ee");
      chk("ee_literal", res_data, {32{8'hEE}});
      fill_lanes(14'h03FF);
      run_txn('0, 0, 1'b0, "low_bits");
      chk("low_bits_literal", res_data, 256'(0));
      fill_lanes(14'h3FFF);
      run_txn('0, 0, 1'b0, "all_ones");
      chk("all_ones_literal", res_data, {256{1'b1}});

      // Randomized products, some with backpressure and stray hash_valid pulses
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < NPE_T; i++) lane_val[i] = 14'($urandom);
         run_txn(rand256(), (t % 2 == 1) ? 10 : 0, (t >= 2), $sformatf("rnd%0d", t));
      end

      // hash_valid held through the OUT handshake must not be accepted until IDLE
      for (int i = 0; i < NPE_T; i++) lane_val[i] = 14'($urandom);
      apply_lanes();
      dg = rand256();
      exp_r = model(dg);
      run_txn(rand256(), 4, 1'b0, "pre_hold");
      hash_data  = dg;
      hash_valid = 1'b1;
      chk("hold_idle_hready", 256'(hash_ready), 256'(1));
      chk("hold_idle_pe_clr", 256'(pe_clr), 256'(0));
      tick();
      hash_valid = 1'b0;
      chk("hold_accept_pe_clr", 256'(pe_clr), 256'(1));
      cnt = 1;
      while (!res_valid && cnt < 40) begin tick(); cnt++; end
      chk("hold_latency", 256'(cnt), 256'(21));
      chk("hold_result", res_data, exp_r);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Reset mid-run, then a clean full run
      fill_lanes(14'h2400);
      apply_lanes();
      hash_data  = rand256();
      hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      cnt = 0;
      while (!(pe_en && beat_idx == 4'd7) && cnt < 40) begin tick(); cnt++; end
      chk("mid_rst_reached_beat7", 256'(beat_idx), 256'(7));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_pe_en", 256'(pe_en), 256'(0));
      chk("mid_rst_pe_clr", 256'(pe_clr), 256'(0));
      chk("mid_rst_rvalid", 256'(res_valid), 256'(0));
      chk("mid_rst_hready", 256'(hash_ready), 256'(1));
      chk("mid_rst_rdata", res_data, 256'(0));
      fill_lanes(14'h1C00);
      run_txn(rand256(), 2, 1'b1, "post_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
